// File: rtl/dport_pkg.sv
// Shared types and constants for the data-port capture engine.
package dport_pkg;

  typedef enum logic {
    CAP_CAPTURE = 1'b0,
    CAP_FROZEN  = 1'b1
  } cap_state_e;

  localparam int DPORT_STOP = 0;
  localparam int DPORT_WRAP = 1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dport_capture.sv
// Captures data-port beats into a buffer until done or cycle-limit timeout,
// with stop/ring modes, overflow reporting and a logical-index read port.
module dport_capture
  import dport_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WRAP        = 0,
  parameter int CYCLE_LIMIT = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        dport_out,
  input  logic                     dport_write,
  input  logic                     done,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     finished,
  output logic                     timeout,
  output logic                     o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CYCLE_LIMIT > 0) ? $clog2(CYCLE_LIMIT + 1) : 1;
  localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LIMIT_M1  = CW'((CYCLE_LIMIT > 0) ? CYCLE_LIMIT - 1 : 0);

  cap_state_e        r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_count;
  logic [CW-1:0]     r_cyc_cnt;
  logic              r_overflow;
  logic              r_timeout;

  logic              w_capture;
  logic              w_full;
  logic              w_accept;
  logic              w_limit_hit;
  logic              w_trigger;
  logic [AW-1:0]     w_oldest;
  logic [AW-1:0]     w_rd_phys;

  assign w_capture   = (r_state == CAP_CAPTURE);
  assign w_full      = (r_count == COUNT_MAX);
  assign w_accept    = w_capture && dport_write && (!w_full || WRAP == DPORT_WRAP);
  assign w_limit_hit = (CYCLE_LIMIT != 0) && (r_cyc_cnt == LIMIT_M1);
  assign w_trigger   = done || w_limit_hit;

  // Once a ring buffer has wrapped, the next slot to be overwritten is the oldest.
  assign w_oldest  = (WRAP == DPORT_WRAP && w_full) ? r_wr_ptr : '0;
  assign w_rd_phys = w_oldest + rd_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CAP_CAPTURE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_cyc_cnt  <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (!w_full) begin
          r_count <= r_count + (AW + 1)'(1);
        end
      end
      if (w_capture && dport_write && w_full) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        CAP_CAPTURE: begin
          if (w_trigger) begin
            r_state   <= CAP_FROZEN;
            r_timeout <= w_limit_hit && !done;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          end
        end
        default: r_state <= CAP_FROZEN;
      endcase
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept && rst_n),
    .i_waddr (r_wr_ptr),
    .i_wdata (dport_out),
    .i_raddr (w_rd_phys),
    .o_rdata (rd_data)
  );

  assign count       = r_count;
  assign full        = w_full;
  assign overflow    = r_overflow;
  assign finished    = (r_state == CAP_FROZEN);
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dport_capture.sv
// Bench for dport_capture: three configurations (stop/4, ring/4, stop/16 with
// a 10-cycle limit) share one stimulus stream and a list-based reference model.
module tb_dport_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dport_out = '0;
  logic       dport_write = 1'b0;
  logic       done = 1'b0;
  logic [3:0] rd_addr = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic [7:0] rd0, rd1, rd2;
  logic [2:0] cnt0, cnt1;
  logic [4:0] cnt2;
  logic       full0, full1, full2, ov0, ov1, ov2, fin0, fin1, fin2;
  logic       to0, to1, to2, st0, st1, st2;

  dport_capture #(.DATA_W(8), .DEPTH(4), .WRAP(0), .CYCLE_LIMIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .dport_out(dport_out), .dport_write(dport_write),
    .done(done), .rd_addr(rd_addr[1:0]), .rd_data(rd0), .count(cnt0), .full(full0),
    .overflow(ov0), .finished(fin0), .timeout(to0), .o_dbg_state(st0));

  dport_capture #(.DATA_W(8), .DEPTH(4), .WRAP(1), .CYCLE_LIMIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .dport_out(dport_out), .dport_write(dport_write),
    .done(done), .rd_addr(rd_addr[1:0]), .rd_data(rd1), .count(cnt1), .full(full1),
    .overflow(ov1), .finished(fin1), .timeout(to1), .o_dbg_state(st1));

  dport_capture #(.DATA_W(8), .DEPTH(16), .WRAP(0), .CYCLE_LIMIT(10)) u2 (
    .clk(clk), .rst_n(rst_n), .dport_out(dport_out), .dport_write(dport_write),
    .done(done), .rd_addr(rd_addr), .rd_data(rd2), .count(cnt2), .full(full2),
    .overflow(ov2), .finished(fin2), .timeout(to2), .o_dbg_state(st2));

  logic [7:0] a_rd [3];
  logic [4:0] a_cnt [3];
  logic       a_full [3], a_ov [3], a_fin [3], a_to [3], a_st [3];

  assign a_rd[0] = rd0;  assign a_rd[1] = rd1;  assign a_rd[2] = rd2;
  assign a_cnt[0] = {2'b00, cnt0};  assign a_cnt[1] = {2'b00, cnt1};  assign a_cnt[2] = cnt2;
  assign a_full[0] = full0;  assign a_full[1] = full1;  assign a_full[2] = full2;
  assign a_ov[0] = ov0;  assign a_ov[1] = ov1;  assign a_ov[2] = ov2;
  assign a_fin[0] = fin0;  assign a_fin[1] = fin1;  assign a_fin[2] = fin2;
  assign a_to[0] = to0;  assign a_to[1] = to1;  assign a_to[2] = to2;
  assign a_st[0] = st0;  assign a_st[1] = st1;  assign a_st[2] = st2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: logical list, oldest first ----------------
  function automatic int depth_of(input int k); return (k == 2) ? 16 : 4; endfunction
  function automatic bit wrap_of(input int k);  return (k == 1); endfunction
  function automatic int limit_of(input int k); return (k == 2) ? 10 : 0; endfunction

  logic [7:0] m_buf [3][16];
  int         m_size [3];
  int         m_cyc [3];
  bit         m_ov [3], m_fin [3], m_to [3];
  logic [7:0] e_rd [3];
  bit         e_rd_ok [3];

  task automatic model_step(input int k);
    int  d;
    int  ra;
    bit  lim;
    d  = depth_of(k);
    ra = int'(rd_addr) % d;
    if (!rst_n) begin
      m_size[k] = 0; m_cyc[k] = 0; m_ov[k] = 0; m_fin[k] = 0; m_to[k] = 0;
      e_rd[k] = 8'h00; e_rd_ok[k] = 1;
      return;
    end
    e_rd_ok[k] = (ra < m_size[k]);
    e_rd[k]    = m_buf[k][ra];
    if (!m_fin[k]) begin
      if (dport_write) begin
        if (m_size[k] < d) begin
          m_buf[k][m_size[k]] = dport_out;
          m_size[k]++;
        end else begin
          m_ov[k] = 1;
          if (wrap_of(k)) begin
            for (int j = 0; j < d - 1; j++) m_buf[k][j] = m_buf[k][j + 1];
            m_buf[k][d - 1] = dport_out;
          end
        end
      end
      lim = (limit_of(k) != 0) && (m_cyc[k] == limit_of(k) - 1);
      if (done || lim) begin
        m_fin[k] = 1;
        m_to[k]  = lim && !done;
      end else begin
        m_cyc[k]++;
      end
    end
  endtask

  // Compare process: advance the model on each edge, check outputs just after.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.count", k), 32'(a_cnt[k]), 32'(m_size[k]));
      chk($sformatf("u%0d.full", k), 32'(a_full[k]), 32'(m_size[k] == depth_of(k)));
      chk($sformatf("u%0d.overflow", k), 32'(a_ov[k]), 32'(m_ov[k]));
      chk($sformatf("u%0d.finished", k), 32'(a_fin[k]), 32'(m_fin[k]));
      chk($sformatf("u%0d.timeout", k), 32'(a_to[k]), 32'(m_to[k]));
      chk($sformatf("u%0d.state", k), 32'(a_st[k]), 32'(m_fin[k]));
      if (e_rd_ok[k]) chk($sformatf("u%0d.rd_data", k), 32'(a_rd[k]), 32'(e_rd[k]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic w, input logic [7:0] d, input logic dn, input logic [3:0] ra);
    dport_write = w;
    dport_out   = d;
    done        = dn;
    rd_addr     = ra;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 8'h00, 1'b0, 4'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset.rd_data", 32'(rd0), 32'h0);
    chk("reset.count", 32'(cnt0), 32'h0);
    chk("reset.full", 32'(full0), 32'h0);
    chk("reset.flags", {29'h0, ov2, fin2, to2}, 32'h0);

    // Stop mode: three beats then done
    tick(1'b1, 8'h11, 1'b0, 4'd0);
    tick(1'b1, 8'h22, 1'b0, 4'd0);
    tick(1'b1, 8'h33, 1'b0, 4'd0);
    tick(1'b0, 8'h00, 1'b1, 4'd0);
    chk("t1.count", 32'(cnt0), 32'd3);
    chk("t1.finished", 32'(fin0), 32'd1);
    chk("t1.overflow", 32'(ov0), 32'd0);
    chk("t1.timeout", 32'(to0), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 4'd0);  chk("t1.rd0", 32'(rd0), 32'h11);
    tick(1'b0, 8'h00, 1'b0, 4'd1);  chk("t1.rd1", 32'(rd0), 32'h22);
    tick(1'b0, 8'h00, 1'b0, 4'd2);  chk("t1.rd2", 32'(rd0), 32'h33);

    // Six beats into a 4-deep buffer, stop and ring
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 8'hA0 + 8'(i), 1'b0, 4'd0);
    chk("t2.stop.count", 32'(cnt0), 32'd4);
    chk("t2.stop.full", 32'(full0), 32'd1);
    chk("t2.stop.overflow", 32'(ov0), 32'd1);
    chk("t2.ring.count", 32'(cnt1), 32'd4);
    chk("t2.ring.overflow", 32'(ov1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'h00, 1'b0, 4'(i));
      chk($sformatf("t2.stop.rd%0d", i), 32'(rd0), 32'(8'hA0 + 8'(i)));
      chk($sformatf("t2.ring.rd%0d", i), 32'(rd1), 32'(8'hA2 + 8'(i)));
    end

    // Cycle-limit timeout with a write on every cycle
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 8'(i), 1'b0, 4'd0);
      chk($sformatf("t3.finished@%0d", i), 32'(fin2), 32'(i >= 10));
      chk($sformatf("t3.timeout@%0d", i), 32'(to2), 32'(i >= 10));
    end
    chk("t3.count", 32'(cnt2), 32'd10);
    tick(1'b0, 8'h00, 1'b0, 4'd9);
    chk("t3.rd9", 32'(rd2), 32'd10);

    // done coinciding with a beat
    do_reset();
    tick(1'b1, 8'h5A, 1'b1, 4'd0);
    chk("t4.finished", 32'(fin0), 32'd1);
    chk("t4.timeout", 32'(to0), 32'd0);
    chk("t4.count", 32'(cnt0), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 4'd0);
    chk("t4.rd0", 32'(rd0), 32'h5A);

    // One-cycle reset pulse mid-capture
    do_reset();
    tick(1'b1, 8'h01, 1'b0, 4'd0);
    tick(1'b1, 8'h02, 1'b0, 4'd0);
    rst_n = 1'b0;
    tick(1'b0, 8'h00, 1'b0, 4'd1);
    chk("t5.count", 32'(cnt0), 32'd0);
    chk("t5.rd_data", 32'(rd0), 32'h0);
    chk("t5.flags", {28'h0, full0, ov0, fin0, to0}, 32'h0);
    rst_n = 1'b1;
    tick(1'b1, 8'h77, 1'b0, 4'd0);
    tick(1'b0, 8'h00, 1'b0, 4'd0);
    chk("t5.rd0", 32'(rd0), 32'h77);
    chk("t5.count_after", 32'(cnt0), 32'd1);

    tick(1'b0, 8'h00, 1'b0, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
